// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit core: sequences fetch/decode/
// execute/memory/writeback with bounded memory waits and retire counting.
module multicycle_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ack,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             ir_we,
  output logic             rf_we,
  output logic             rf_wsel,
  output logic [3:0]       alu_op,
  output logic             alu_bsel,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_asel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    FAULT  = 3'd6,
    ILL    = 3'd7
  } state_t;

  localparam logic [7:0]       WLIM = 8'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           st_q, st_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= FETCH;
      wcnt_q <= '0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      wcnt_q <= wcnt_d;
      if (retire)
        cnt_q <= cnt_q + ONE;
    end
  end

  always_comb begin
    st_d     = st_q;
    retire   = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'd0;
    ir_we    = 1'b0;
    rf_we    = 1'b0;
    rf_wsel  = 1'b0;
    alu_op   = 4'd0;
    alu_bsel = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_asel = 1'b0;
    unique case (st_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          st_d  = DECODE;
        end else if (wcnt_q == WLIM) begin
          st_d = FAULT;
        end
      end
      DECODE: begin
        unique case (1'b1)
          (opcode == 4'hF): begin
            st_d   = HALT;
            retire = 1'b1;
          end
          (opcode == 4'hC): begin
            pc_we  = 1'b1;
            pc_sel = 2'd2;
            st_d   = FETCH;
            retire = 1'b1;
          end
          (opcode == 4'hD || opcode == 4'hE): begin
            st_d   = FETCH;
            retire = 1'b1;
          end
          default: st_d = EXEC;
        endcase
      end
      EXEC: begin
        unique case (1'b1)
          (!opcode[3]): begin
            alu_op = opcode;
            st_d   = WB;
          end
          (opcode == 4'h8): begin
            alu_bsel = 1'b1;
            st_d     = WB;
          end
          (opcode == 4'h9 || opcode == 4'hA): begin
            alu_bsel = 1'b1;
            st_d     = MEM;
          end
          (opcode == 4'hB): begin
            alu_op = 4'd1;
            if (alu_zero) begin
              pc_we  = 1'b1;
              pc_sel = 2'd1;
            end
            st_d   = FETCH;
            retire = 1'b1;
          end
          default: st_d = FAULT;
        endcase
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_asel = 1'b1;
        mem_we   = (opcode == 4'hA);
        alu_bsel = 1'b1;
        if (mem_ack) begin
          st_d   = (opcode == 4'hA) ? FETCH : WB;
          retire = (opcode == 4'hA);
        end else if (wcnt_q == WLIM) begin
          st_d = FAULT;
        end
      end
      WB: begin
        rf_we    = 1'b1;
        rf_wsel  = (opcode == 4'h9);
        alu_op   = opcode[3] ? 4'd0 : opcode;
        alu_bsel = opcode[3];
        st_d     = FETCH;
        retire   = 1'b1;
      end
      HALT:  st_d = HALT;
      FAULT: st_d = FAULT;
      default: st_d = FAULT;
    endcase
    // wait counter only runs while a request is stalled in place
    if ((st_q == FETCH || st_q == MEM) && !mem_ack && st_d == st_q)
      wcnt_d = wcnt_q + 8'd1;
    else
      wcnt_d = 8'd0;
    if (rst) begin
      pc_we    = 1'b0;
      pc_sel   = 2'd0;
      ir_we    = 1'b0;
      rf_we    = 1'b0;
      rf_wsel  = 1'b0;
      alu_op   = 4'd0;
      alu_bsel = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_asel = 1'b0;
    end
  end

  assign state       = rst ? 3'd0 : st_q;
  assign halted      = !rst && st_q == HALT;
  assign fault       = !rst && st_q == FAULT;
  assign instr_count = rst ? '0 : cnt_q;

endmodule
